// File: rtl/popcount_arbiter.sv
// Round-robin arbiter feeding one shared, registered popcount engine.
// One word is in flight at a time; the result comes back tagged with its requester index.
module popcount_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    localparam int CW  = $clog2(W + 1),
    localparam int IW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*W-1:0]   req_data,
    output logic [NREQ-1:0]     grant,
    output logic                busy,
    output logic                res_valid,
    output logic [CW-1:0]       res_count,
    output logic [IW-1:0]       res_id,
    input  logic                res_ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CAPT = 2'd1,
        S_CNT  = 2'd2,
        S_RES  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [IW-1:0]      r_ptr;
    logic [IW-1:0]      r_winner;
    logic [W-1:0]       r_capt;
    logic [NREQ-1:0]    r_grant;
    logic               r_res_valid;
    logic [CW-1:0]      r_res_count;
    logic [IW-1:0]      r_res_id;
    logic [IW-1:0]      w_winner;
    logic               w_found;
    logic               w_handshake;

    function automatic logic [CW-1:0] f_popcount(input logic [W-1:0] d);
        logic [CW-1:0] s;
        s = '0;
        for (int i = 0; i < W; i++) begin
            s = s + CW'(d[i]);
        end
        return s;
    endfunction

    function automatic logic [IW-1:0] f_next_idx(input logic [IW-1:0] idx);
        return IW'((int'(idx) + 1) % NREQ);
    endfunction

    // Rotating search starting at r_ptr; first pending requester wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && req[(int'(r_ptr) + k) % NREQ]) begin
                w_found  = 1'b1;
                w_winner = IW'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    assign w_handshake = r_res_valid & res_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_next_state = S_CAPT;
            S_CAPT:  w_next_state = S_CNT;
            S_CNT:   w_next_state = S_RES;
            S_RES:   if (w_handshake) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr       <= '0;
            r_winner    <= '0;
            r_capt      <= '0;
            r_grant     <= '0;
            r_res_valid <= 1'b0;
            r_res_count <= '0;
            r_res_id    <= '0;
        end else begin
            r_grant <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_capt   <= req_data[int'(w_winner)*W +: W];
                        r_winner <= w_winner;
                        r_grant  <= {{(NREQ-1){1'b0}}, 1'b1} << w_winner;
                    end
                end
                S_CAPT: begin
                    r_res_count <= f_popcount(r_capt);
                end
                S_CNT: begin
                    r_res_valid <= 1'b1;
                    r_res_id    <= r_winner;
                end
                S_RES: begin
                    // Pointer advances only on acceptance, so the next IDLE arbitration sees it.
                    if (w_handshake) begin
                        r_res_valid <= 1'b0;
                        r_ptr       <= f_next_idx(r_winner);
                    end
                end
                default: ;
            endcase
        end
    end

    assign grant     = r_grant;
    assign busy      = (r_state != S_IDLE);
    assign res_valid = r_res_valid;
    assign res_count = r_res_count;
    assign res_id    = r_res_id;

endmodule

// File: tb/tb_popcount_arbiter.sv
// Directed bench for popcount_arbiter: reset, latency, round-robin order, backpressure,
// mid-flight reset and fairness with a continuously held request.
module tb_popcount_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  grant;
    logic        busy;
    logic        res_valid;
    logic [3:0]  res_count;
    logic [1:0]  res_id;
    logic        res_ready;

    int n_tests = 0;
    int n_fail  = 0;

    popcount_arbiter #(.NREQ(4), .W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_data  (req_data),
        .grant     (grant),
        .busy      (busy),
        .res_valid (res_valid),
        .res_count (res_count),
        .res_id    (res_id),
        .res_ready (res_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!busy && !res_valid) begin
                ok = 1'b1;
                break;
            end
        end
        n_tests++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_idle_timeout: busy=%b res_valid=%b, required idle within 20 cycles", tag, busy, res_valid);
        end
    endtask

    task automatic test_reset;
        reset     = 1'b0;
        req       = 4'hF;
        req_data  = 32'hAA0F0100;
        res_ready = 1'b1;
        @(negedge clk); #1;
        n_tests++;
        if ({grant, busy, res_valid} !== 6'b0) begin
            n_fail++;
            $display("FAIL t1_rst_ctrl: grant=%b busy=%b res_valid=%b, required all 0", grant, busy, res_valid);
        end
        n_tests++;
        if ({res_count, res_id} !== 6'b0) begin
            n_fail++;
            $display("FAIL t1_rst_res: res_count=%0d res_id=%0d, required 0/0", res_count, res_id);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if (grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL t1_first_grant: got %b, required 0001", grant);
        end
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL t1_busy: got %b, required 1", busy);
        end
        req = 4'h0;
        wait_idle("t1");
    endtask

    task automatic test_single;
        req_data  = 32'h00FF0000;
        req       = 4'b0100;
        res_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (grant !== 4'b0100) begin
            n_fail++;
            $display("FAIL t2_grant: got %b, required 0100", grant);
        end
        req = 4'h0;
        @(negedge clk);
        n_tests++;
        if ({grant, res_valid} !== 5'b0) begin
            n_fail++;
            $display("FAIL t2_capt: grant=%b res_valid=%b, required 0000/0", grant, res_valid);
        end
        @(negedge clk);
        n_tests++;
        if ({res_valid, res_count, res_id} !== {1'b1, 4'd8, 2'd2}) begin
            n_fail++;
            $display("FAIL t2_result: valid=%b count=%0d id=%0d, required 1/8/2", res_valid, res_count, res_id);
        end
        @(negedge clk);
        n_tests++;
        if ({res_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL t2_after_hs: valid=%b busy=%b, required 0/0", res_valid, busy);
        end
    endtask

    task automatic test_round_robin;
        int         t;
        int         last;
        bit         found;
        logic [1:0] exp_id    [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [3:0] exp_count [5] = '{4'd0, 4'd1, 4'd4, 4'd4, 4'd0};
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset     = 1'b1;
        req_data  = 32'hAA0F0100;
        req       = 4'hF;
        res_ready = 1'b1;
        t    = 0;
        last = 0;
        for (int j = 0; j < 5; j++) begin
            found = 1'b0;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                t++;
                if (res_valid) begin
                    found = 1'b1;
                    break;
                end
            end
            n_tests++;
            if (found !== 1'b1) begin
                n_fail++;
                $display("FAIL t3_timeout_%0d: no res_valid within 8 cycles", j);
            end
            n_tests++;
            if ({res_id, res_count} !== {exp_id[j], exp_count[j]}) begin
                n_fail++;
                $display("FAIL t3_result_%0d: id=%0d count=%0d, required id=%0d count=%0d",
                         j, res_id, res_count, exp_id[j], exp_count[j]);
            end
            if (j > 0) begin
                n_tests++;
                if (t - last !== 4) begin
                    n_fail++;
                    $display("FAIL t3_period_%0d: got %0d cycles, required 4", j, t - last);
                end
            end
            last = t;
        end
        req = 4'h0;
        wait_idle("t3");
    endtask

    task automatic test_backpressure;
        req_data  = 32'h0000813C;
        req       = 4'b0001;
        res_ready = 1'b0;
        @(negedge clk);
        n_tests++;
        if (grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL t4_grant0: got %b, required 0001", grant);
        end
        req = 4'b0010;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_tests++;
            if ({res_valid, res_count, res_id, grant, busy} !== {1'b1, 4'd4, 2'd0, 4'b0000, 1'b1}) begin
                n_fail++;
                $display("FAIL t4_hold_%0d: valid=%b count=%0d id=%0d grant=%b busy=%b, required 1/4/0/0000/1",
                         k, res_valid, res_count, res_id, grant, busy);
            end
        end
        res_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({res_valid, grant} !== 5'b0) begin
            n_fail++;
            $display("FAIL t4_after_hs: valid=%b grant=%b, required 0/0000", res_valid, grant);
        end
        @(negedge clk);
        n_tests++;
        if (grant !== 4'b0010) begin
            n_fail++;
            $display("FAIL t4_grant1: got %b, required 0010", grant);
        end
        req = 4'h0;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if ({res_valid, res_count, res_id} !== {1'b1, 4'd2, 2'd1}) begin
            n_fail++;
            $display("FAIL t4_result1: valid=%b count=%0d id=%0d, required 1/2/1", res_valid, res_count, res_id);
        end
        wait_idle("t4");
    endtask

    task automatic test_reset_midflight;
        req_data  = 32'h11FF0755;
        req       = 4'b0100;
        res_ready = 1'b0;
        @(negedge clk);
        n_tests++;
        if (grant !== 4'b0100) begin
            n_fail++;
            $display("FAIL t5_grant_a: got %b, required 0100", grant);
        end
        req = 4'h0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_tests++;
        if ({grant, busy, res_valid, res_count, res_id} !== 12'b0) begin
            n_fail++;
            $display("FAIL t5_rst_cnt: grant=%b busy=%b valid=%b count=%0d id=%0d, required all 0",
                     grant, busy, res_valid, res_count, res_id);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({res_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL t5_stale_a: valid=%b busy=%b, required 0/0", res_valid, busy);
        end
        req = 4'b1010;
        @(negedge clk);
        n_tests++;
        if (grant !== 4'b0010) begin
            n_fail++;
            $display("FAIL t5_grant_b: got %b, required 0010", grant);
        end
        req = 4'h0;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (res_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL t5_in_res: valid=%b, required 1", res_valid);
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if ({grant, busy, res_valid, res_count, res_id} !== 12'b0) begin
            n_fail++;
            $display("FAIL t5_rst_res: grant=%b busy=%b valid=%b count=%0d id=%0d, required all 0",
                     grant, busy, res_valid, res_count, res_id);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({res_valid, busy, grant} !== 6'b0) begin
            n_fail++;
            $display("FAIL t5_stale_b: valid=%b busy=%b grant=%b, required 0/0/0000", res_valid, busy, grant);
        end
        req       = 4'b1001;
        res_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL t5_grant_c: got %b, required 0001", grant);
        end
        req = 4'h0;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if ({res_valid, res_count, res_id} !== {1'b1, 4'd4, 2'd0}) begin
            n_fail++;
            $display("FAIL t5_result_c: valid=%b count=%0d id=%0d, required 1/4/0", res_valid, res_count, res_id);
        end
        wait_idle("t5");
    endtask

    task automatic test_fairness;
        logic [3:0] seq [$];
        req_data  = 32'hF0000001;
        req       = 4'b1000;
        res_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            n_tests++;
            if ((grant & (grant - 4'd1)) !== 4'b0) begin
                n_fail++;
                $display("FAIL t6_onehot_%0d: grant=%b, required one-hot or zero", i, grant);
            end
            n_tests++;
            if ((|grant && res_valid) !== 1'b0) begin
                n_fail++;
                $display("FAIL t6_overlap_%0d: grant=%b res_valid=%b, required no overlap", i, grant, res_valid);
            end
            if (grant != 4'b0) seq.push_back(grant);
            if (i == 2) req[0] = 1'b1;
            if (grant == 4'b0001) req[0] = 1'b0;
        end
        req = 4'h0;
        n_tests++;
        if (seq.size() < 3) begin
            n_fail++;
            $display("FAIL t6_grant_count: got %0d grants, required at least 3", seq.size());
        end else begin
            n_tests++;
            if ({seq[0], seq[1], seq[2]} !== {4'b1000, 4'b0001, 4'b1000}) begin
                n_fail++;
                $display("FAIL t6_order: got %b %b %b, required 1000 0001 1000", seq[0], seq[1], seq[2]);
            end
        end
        wait_idle("t6");
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reset_midflight();
        test_fairness();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
